// File: rtl/aes_pkg.sv
// Purpose : shared AES definitions (round count, Rcon, FSM encoding, word byte-order helpers).
// Latency : n/a (package, combinational helpers only).
// Backpr. : n/a.
package aes_pkg;

  localparam int AES_NR = 10;

  // One-hot FSM encoding for the key-schedule engines.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    EMIT0 = 4'b0010,
    SUB   = 4'b0100,
    MIX   = 4'b1000
  } state_e;

  // Round constant for round r (1..10); every other index yields 0.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // RotWord on a big-endian word: first byte ([31:24]) moves to the end.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_sbox.sv
// Purpose : 32-bit S-box word stage, four parallel AES S-box lookups on a big-endian word.
// Latency : 1 cycle, data_out registered; holds its value while enable_in is low.
// Backpr. : none, one lookup per enabled cycle.
// Ports   : clk_in clock; enable_in load strobe; data_in word to substitute; data_out SubWord(data_in).
module getSBoxValue_cipher (
  input  logic        clk_in,
  input  logic        enable_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  // Byte 0x00 sits in the top byte, byte 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

  always_ff @(posedge clk_in) begin
    if (enable_in) begin
      data_out <= {sub_byte(data_in[31:24]), sub_byte(data_in[23:16]),
                   sub_byte(data_in[15:8]),  sub_byte(data_in[7:0])};
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// Purpose : iterative AES-128 key schedule, streams round keys 0..10 to the round-key store.
// Latency : key 0 one cycle after start accepted, then one key every 2 cycles; done with key 10.
// Backpr. : none; start_in is ignored unless idle, the consumer must take every rk_valid_out strobe.
// Ports   : clk_in/rst_in clock and sync reset; start_in/key_in request; busy_out, rk_valid_out,
//           rk_index_out, rk_out, done_out registered result stream.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic [127:0] key_in,
  output logic         busy_out,
  output logic         rk_valid_out,
  output logic [3:0]   rk_index_out,
  output logic [127:0] rk_out,
  output logic         done_out
);

  localparam logic [3:0] LAST_R = 4'(NR);

  state_e         state_q, state_d;
  logic [127:0]   w_q, w_d;
  logic [3:0]     r_q, r_d;
  logic           busy_q, busy_d;
  logic           rk_valid_q, rk_valid_d;
  logic [3:0]     rk_index_q, rk_index_d;
  logic [127:0]   rk_q, rk_d;
  logic           done_q, done_d;

  logic           sbox_en;
  logic [31:0]    sbox_din;
  logic [31:0]    sbox_dout;

  // Outputs are registered, so each state's visible result is computed in the
  // preceding cycle. The S-box is therefore loaded on the edge entering SUB,
  // its word is consumed during SUB, and the new key lands on the edge into MIX.
  getSBoxValue_cipher u_sbox (
    .clk_in    (clk_in),
    .enable_in (sbox_en),
    .data_in   (sbox_din),
    .data_out  (sbox_dout)
  );

  logic [31:0] t_word, w0_n, w1_n, w2_n, w3_n;

  assign t_word = sbox_dout ^ {rcon(r_q), 24'h0};
  assign w0_n   = w_q[127:96] ^ t_word;
  assign w1_n   = w_q[95:64]  ^ w0_n;
  assign w2_n   = w_q[63:32]  ^ w1_n;
  assign w3_n   = w_q[31:0]   ^ w2_n;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    r_d        = r_q;
    busy_d     = busy_q;
    rk_valid_d = 1'b0;
    rk_index_d = rk_index_q;
    rk_d       = rk_q;
    done_d     = 1'b0;
    sbox_en    = 1'b0;
    sbox_din   = rot_word(w_q[31:0]);

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d    = EMIT0;
          w_d        = key_in;
          r_d        = 4'd0;
          busy_d     = 1'b1;
          rk_valid_d = 1'b1;
          rk_index_d = 4'd0;
          rk_d       = key_in;
        end
      end
      EMIT0: begin
        state_d = SUB;
        r_d     = 4'd1;
        sbox_en = 1'b1;
      end
      SUB: begin
        state_d    = MIX;
        w_d        = {w0_n, w1_n, w2_n, w3_n};
        rk_d       = {w0_n, w1_n, w2_n, w3_n};
        rk_valid_d = 1'b1;
        rk_index_d = r_q;
        done_d     = (r_q == LAST_R);
      end
      MIX: begin
        if (r_q == LAST_R) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = SUB;
          r_d     = r_q + 4'd1;
          // w_q already holds this round's key, so RotWord(w3) is ready now.
          sbox_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      w_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_index_q <= '0;
      rk_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      rk_index_q <= rk_index_d;
      rk_q       <= rk_d;
      done_q     <= done_d;
    end
  end

  assign busy_out     = busy_q;
  assign rk_valid_out = rk_valid_q;
  assign rk_index_out = rk_index_q;
  assign rk_out       = rk_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Purpose : self-checking bench for aes_key_expand (known-answer table, restart/reset corners, random keys).
// Latency : n/a.
// Backpr. : n/a.
module tb_aes_key_expand;

  logic         clk_in;
  logic         rst_in;
  logic         start_in;
  logic [127:0] key_in;
  logic         busy_out;
  logic         rk_valid_out;
  logic [3:0]   rk_index_out;
  logic [127:0] rk_out;
  logic         done_out;

  aes_key_expand #(.NR(10)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .key_in       (key_in),
    .busy_out     (busy_out),
    .rk_valid_out (rk_valid_out),
    .rk_index_out (rk_index_out),
    .rk_out       (rk_out),
    .done_out     (done_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;

  always @(negedge clk_in) if (rk_valid_out === 1'b1) strobes++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: S-box built from GF(2^8) inversion plus the affine map,
  // Rcon generated by repeated doubling.
  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk [11];
  logic [127:0] cap_rk [11];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15 - n -: 8];
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b   = 8'(v);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, b);
      if (v == 0) inv = 8'h00;
      sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [127:0] w  = key;
    logic [7:0]   rc = 8'h01;
    logic [31:0]  t, a, b, c, d;
    exp_rk[0] = key;
    for (int r = 1; r <= 10; r++) begin
      t = {sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]], sbox_ref[w[31:24]]} ^ {rc, 24'h0};
      a = w[127:96] ^ t;
      b = w[95:64] ^ a;
      c = w[63:32] ^ b;
      d = w[31:0] ^ c;
      w = {a, b, c, d};
      exp_rk[r] = w;
      rc = xtime(rc);
    end
  endtask

  // Starts an expansion in the current cycle (relative cycle 0) and checks
  // every cycle 1..22. start_in is held while c < hold_until and pulsed at
  // cycles pa/pb. Returns positioned in relative cycle 22.
  task automatic run_exp(input logic [127:0] key, input int hold_until, input int pa, input int pb);
    logic exp_busy, exp_valid, exp_done;
    int   k;
    model_expand(key);
    start_in = 1'b1;
    key_in   = key;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk_in); #1;
      start_in = (c < hold_until) || (c == pa) || (c == pb);
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      exp_busy  = (c <= 21);
      exp_valid = (c % 2 == 1) && (c <= 21);
      exp_done  = (c == 21);
      chk($sformatf("busy/valid/done c%0d", c), 128'({busy_out, rk_valid_out, done_out}),
          128'({exp_busy, exp_valid, exp_done}));
      if (exp_valid) begin
        k = (c - 1) / 2;
        cap_rk[k] = rk_out;
        chk($sformatf("rk_index c%0d", c), 128'(rk_index_out), 128'(k));
        chk($sformatf("rk%0d c%0d", k, c), rk_out, exp_rk[k]);
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
    end
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  vec_t vecs [3];
  int   s0;

  initial begin
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h00000000000000000000000000000000,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5};

    build_sbox();
    rst_in   = 1'b1;
    start_in = 1'b0;
    key_in   = '0;
    step(3);
    chk("reset ctl", 128'({busy_out, rk_valid_out, done_out, rk_index_out}), 128'(0));
    chk("reset rk_out", rk_out, 128'h0);
    rst_in = 1'b0;
    step(2);
    chk("idle ctl", 128'({busy_out, rk_valid_out, done_out, rk_index_out}), 128'(0));

    // Known-answer table.
    for (int v = 0; v < 3; v++) begin
      run_exp(vecs[v].key, 0, -1, -1);
      chk($sformatf("kat%0d rk0", v), cap_rk[0], vecs[v].key);
      chk($sformatf("kat%0d rk1", v), cap_rk[1], vecs[v].rk1);
      chk($sformatf("kat%0d rk10", v), cap_rk[10], vecs[v].rk10);
      step(3);
    end

    // start_in held for 30 cycles: one expansion, restart at cycle 22 only.
    s0 = strobes;
    run_exp(vecs[0].key, 99, -1, -1);
    run_exp(vecs[1].key, 8, -1, -1);
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("after hold idle", 128'({busy_out, rk_valid_out, done_out}), 128'(0));
    end
    chk("hold strobe count", 128'(strobes - s0), 128'(22));

    // Pulses at cycle 5 and on the done cycle are ignored.
    s0 = strobes;
    run_exp(vecs[2].key, 0, 5, 21);
    step(4);
    chk("pulse strobe count", 128'(strobes - s0), 128'(11));
    chk("pulse idle busy", 128'(busy_out), 128'(0));

    // Reset mid-operation at cycle 8, restart at cycle 12.
    start_in = 1'b1;
    key_in   = vecs[0].key;
    step(1);
    start_in = 1'b0;
    step(7);
    rst_in = 1'b1;
    step(1);
    rst_in = 1'b0;
    s0 = strobes;
    for (int c = 9; c <= 11; c++) begin
      chk($sformatf("rst ctl c%0d", c), 128'({busy_out, rk_valid_out, done_out, rk_index_out}), 128'(0));
      chk($sformatf("rst rk c%0d", c), rk_out, 128'h0);
      step(1);
    end
    chk("rst no strobes", 128'(strobes - s0), 128'(0));
    run_exp(vecs[1].key, 0, -1, -1);
    chk("post-rst rk10", cap_rk[10], vecs[1].rk10);

    // 200 random keys back-to-back.
    for (int n = 0; n < 200; n++) begin
      run_exp({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1);
    end
    start_in = 1'b0;
    step(3);
    chk("final idle", 128'({busy_out, rk_valid_out, done_out}), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key-schedule engine. It expands a 128-bit cipher key into the 11 round keys, one round key every two cycles. Each round's SubWord(RotWord(w)) is computed by one instance of the existing 32-bit S-box word stage. Round keys stream to the round-key store that feeds the cipher datapath.

## Interface
Parameters:
- `NR`, 10, number of rounds. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- `clk_in`  in  1  single clock, rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `start_in`  in  1  one-cycle request to begin expansion; sampled only in IDLE.
- `key_in`  in  128  cipher key; byte 0 is `[127:120]`; sampled on the accepted `start_in` cycle.
- `busy_out`  out  1  high from the cycle after start is accepted up to and including the `done_out` cycle.
- `rk_valid_out`  out  1  one-cycle strobe; `rk_out` and `rk_index_out` are valid.
- `rk_index_out`  out  4  round-key number, 0..10.
- `rk_out`  out  128  round key, word 0 in `[127:96]`.
- `done_out`  out  1  one-cycle pulse, coincident with round key 10.

## Operation
- Words use big-endian byte order: `[31:24]` is the first byte, consistent with the S-box word stage.
- Internal state:
  - `w[0..3]`: 128-bit current round key.
  - Round counter `r`: 4 bits.
  - 1-hot state register.
- States and transitions:
  - IDLE: when `start_in` is high, `w` ← `key_in`, `r` ← 0, go to EMIT0.
  - EMIT0: output round key 0 (`rk_valid_out`=1, index 0), `r` ← 1, go to SUB.
  - SUB: drive S-box `data_in` = RotWord(w3) = `{w3[23:0], w3[31:24]}` with enable high, go to MIX.
  - MIX: compute the new round key, update `w`, output it with index `r`. If `r`==NR, pulse `done_out` and go to IDLE. Otherwise `r` ← `r`+1 and go to SUB.
- MIX key computation, where t = S-box out XOR `{rcon(r), 24'h0}`:
  - w0' = w0 ^ t
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- rcon(1..10) = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex). Index 0 and 11..15 map to 00.
- All arithmetic is bitwise XOR; there are no carries and no width growth.
- Boundary conditions:
  - `start_in` while busy is ignored; there is no queuing and no error flag.
  - `start_in` in the same cycle `done_out` fires is ignored. The earliest accepted restart is the first IDLE cycle.
  - `key_in` is not required to be stable after the accepting cycle.
  - `rst_in` mid-operation aborts: state goes to IDLE next cycle and all outputs return to reset values. A partial key sequence is never completed.
  - S-box enable is low outside SUB, so the S-box output holds.

## Timing
- Reset values: `busy_out`=0, `rk_valid_out`=0, `rk_index_out`=0, `rk_out`=0, `done_out`=0, state IDLE, `r`=0.
- Outputs are registered.
- S-box stage read latency: 1 cycle. Address is presented in SUB; data is used in MIX.
- With start accepted at cycle 0:
  - `busy_out` rises at cycle 1.
  - Round key k (k=0..10) is valid at cycle 1+2k.
  - Gap of exactly one cycle (`rk_valid_out`=0) between consecutive keys.
  - Round key 10 and `done_out` at cycle 21; `busy_out` falls at cycle 22.
- Minimum start-to-start interval: 22 cycles.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_NR` = 10.
  - Rcon function or localparam table.
  - State-type enum {IDLE, EMIT0, SUB, MIX}.
  - Word byte-order helpers (RotWord). These are reused by the future AES-192/256 schedule and the inverse-key path.
- One sub-module instance: `getSBoxValue_cipher` (u_sbox).
  - `clk_in` → `clk_in`; `enable_in` high only in SUB.
- No other hierarchy; the word XOR chain is inline.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start at cycle 0:
  - Index 0 at cycle 1 equals the key.
  - Index 1 at cycle 3 = a0fafe1788542cb123a339392a6c7605.
  - Index 10 at cycle 21 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `done_out`=1.
- All-zero key:
  - Index 1 = 62636363626363636263636362636363.
  - Index 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- `start_in` held high for 30 cycles:
  - Exactly one expansion for cycles 0..21.
  - A second expansion is accepted at the first IDLE cycle (cycle 22), with keys at 23+2k.
- `start_in` pulsed at cycles 5 and 21 during an expansion:
  - Both pulses ignored; key sequence unaffected; exactly 11 `rk_valid_out` strobes.
- `rst_in` asserted at cycle 8 (mid-round 3/4):
  - From cycle 9 all outputs are 0 and `busy_out`=0; no further strobes.
  - A new start at cycle 12 produces a correct full sequence.
- Random 200 keys back-to-back: every emitted round key is checked against a reference model. `rk_index_out` increments 0..10 with strict 2-cycle spacing.
